decode: RTL and testbench

Decode and operand-fetch stage of the rv32 pipeline, sitting between fetch and execute. Accepts one instruction per cycle over a valid/ready handshake, drives the register file read addresses, and applies execute/memory-stage bypassing and a load-use interlock. Outputs immediates, control fields, and operands through a single output register to execute.

---
 rtl/decode_pkg.sv | 88 ++++++++
 rtl/decode_if.sv | 24 ++
 rtl/decode_immgen.sv | 39 +++
 rtl/decode.sv | 144 ++++++++++++++
 tb/tb_decode.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/decode_pkg.sv
// rv32 decode-stage shared types: opcodes, immediate formats,
// the decode->execute bundle and instruction field helpers.
package riscv;

  typedef logic [4:0]  addr_t;
  typedef logic [31:0] word_t;

  typedef enum logic [6:0] {
    LUI      = 7'b0110111,
    AUIPC    = 7'b0010111,
    JAL      = 7'b1101111,
    JALR     = 7'b1100111,
    BRANCH   = 7'b1100011,
    LOAD     = 7'b0000011,
    STORE    = 7'b0100011,
    OP_IMM   = 7'b0010011,
    OP       = 7'b0110011,
    MISC_MEM = 7'b0001111,
    SYSTEM   = 7'b1110011
  } opcode_t;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_fmt_t;

  typedef struct packed {
    word_t       pc;
    word_t       rs1;
    word_t       rs2;
    word_t       imm;
    addr_t       rd_addr;
    logic        rd_en;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        illegal;
  } id_ex_t;

  function automatic logic [6:0] ir_opcode(word_t ir);
    return ir[6:0];
  endfunction

  function automatic addr_t ir_rd(word_t ir);
    return ir[11:7];
  endfunction

  function automatic addr_t ir_rs1(word_t ir);
    return ir[19:15];
  endfunction

  function automatic addr_t ir_rs2(word_t ir);
    return ir[24:20];
  endfunction

  function automatic logic [2:0] ir_funct3(word_t ir);
    return ir[14:12];
  endfunction

  function automatic logic is_legal(logic [6:0] op);
    case (op)
      LUI, AUIPC, JAL, JALR, BRANCH, LOAD,
      STORE, OP_IMM, OP, MISC_MEM, SYSTEM:
        return 1'b1;
      default:
        return 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs1(logic [6:0] op);
    return !(op == LUI || op == AUIPC || op == JAL);
  endfunction

  function automatic logic uses_rs2(logic [6:0] op);
    return op == OP || op == STORE || op == BRANCH;
  endfunction

  function automatic logic writes_rd(logic [6:0] op);
    return is_legal(op) &&
           !(op == STORE || op == BRANCH ||
             op == MISC_MEM || op == SYSTEM);
  endfunction

endpackage

// File: rtl/decode_if.sv
// Fetch/execute handshake bundle around the decode stage.
// master drives instructions in and accepts results out.
interface decode_if;
  import riscv::*;

  logic  in_valid;
  logic  in_ready;
  word_t in_pc;
  word_t in_ir;
  logic  out_valid;
  logic  out_ready;
  word_t out_pc;

  modport master (
    output in_valid, in_pc, in_ir, out_ready,
    input  in_ready, out_valid, out_pc
  );

  modport slave (
    input  in_valid, in_pc, in_ir, out_ready,
    output in_ready, out_valid, out_pc
  );

endinterface

// File: rtl/decode_immgen.sv
// Immediate generator: picks the rv32 immediate format
// from the opcode and sign-extends it to a full word.
module immgen
  import riscv::*;
(
  input  word_t    ir,
  output word_t    imm,
  output imm_fmt_t fmt
);

  // Format select from opcode
  always_comb begin
    fmt = IMM_NONE;
    case (ir_opcode(ir))
      OP_IMM, LOAD, JALR: fmt = IMM_I;
      STORE:              fmt = IMM_S;
      BRANCH:             fmt = IMM_B;
      LUI, AUIPC:         fmt = IMM_U;
      JAL:                fmt = IMM_J;
      default:            fmt = IMM_NONE;
    endcase
  end

  // Bit shuffle and sign extension per format
  always_comb begin
    imm = '0;
    case (fmt)
      IMM_I: imm = {{20{ir[31]}}, ir[31:20]};
      IMM_S: imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      IMM_B: imm = {{19{ir[31]}}, ir[31], ir[7],
                    ir[30:25], ir[11:8], 1'b0};
      IMM_U: imm = {ir[31:12], 12'b0};
      IMM_J: imm = {{11{ir[31]}}, ir[31], ir[19:12],
                    ir[20], ir[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode.sv
// rv32 decode / operand-fetch stage with ex/mem bypass,
// load-use interlock and a single output register.
module decode
  import riscv::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       in_valid,
  output logic       in_ready,
  input  word_t      in_pc,
  input  word_t      in_ir,
  output addr_t      rs1_addr,
  output addr_t      rs2_addr,
  input  word_t      rs1_data,
  input  word_t      rs2_data,
  input  logic       ex_rd_en,
  input  addr_t      ex_rd_addr,
  input  word_t      ex_rd_data,
  input  logic       ex_is_load,
  input  logic       mem_rd_en,
  input  addr_t      mem_rd_addr,
  input  word_t      mem_rd_data,
  input  logic       flush,
  output logic       out_valid,
  input  logic       out_ready,
  output word_t      out_pc,
  output word_t      out_rs1,
  output word_t      out_rs2,
  output word_t      out_imm,
  output addr_t      out_rd_addr,
  output logic       out_rd_en,
  output logic [6:0] out_opcode,
  output logic [2:0] out_funct3,
  output logic       out_funct7b5,
  output logic       out_illegal
);

  logic [6:0] op;
  logic       stall;
  word_t      rs1_val;
  word_t      rs2_val;
  word_t      imm;
  imm_fmt_t   fmt;
  id_ex_t     dec;
  id_ex_t     out_d, out_q;
  logic       out_valid_d, out_valid_q;

  assign op       = ir_opcode(in_ir);
  assign rs1_addr = ir_rs1(in_ir);
  assign rs2_addr = ir_rs2(in_ir);

  immgen u_immgen (
    .ir  (in_ir),
    .imm (imm),
    .fmt (fmt)
  );

  // Load-use interlock and input handshake
  always_comb begin
    stall = 1'b0;
    if (ex_is_load && ex_rd_en && ex_rd_addr != '0) begin
      if (uses_rs1(op) && ex_rd_addr == rs1_addr)
        stall = 1'b1;
      if (uses_rs2(op) && ex_rd_addr == rs2_addr)
        stall = 1'b1;
    end
    in_ready = !stall && (!out_valid_q || out_ready);
  end

  // Operand bypass: x0, then execute, then memory, then RF
  always_comb begin
    rs1_val = rs1_data;
    if (rs1_addr == '0)
      rs1_val = '0;
    else if (ex_rd_en && !ex_is_load &&
             ex_rd_addr == rs1_addr)
      rs1_val = ex_rd_data;
    else if (mem_rd_en && mem_rd_addr == rs1_addr)
      rs1_val = mem_rd_data;

    rs2_val = rs2_data;
    if (rs2_addr == '0)
      rs2_val = '0;
    else if (ex_rd_en && !ex_is_load &&
             ex_rd_addr == rs2_addr)
      rs2_val = ex_rd_data;
    else if (mem_rd_en && mem_rd_addr == rs2_addr)
      rs2_val = mem_rd_data;
  end

  // Decoded bundle for the incoming instruction
  always_comb begin
    dec          = '0;
    dec.pc       = in_pc;
    dec.rs1      = rs1_val;
    dec.rs2      = rs2_val;
    dec.imm      = (fmt == IMM_NONE) ? '0 : imm;
    dec.rd_addr  = ir_rd(in_ir);
    dec.rd_en    = writes_rd(op) && ir_rd(in_ir) != '0;
    dec.opcode   = op;
    dec.funct3   = ir_funct3(in_ir);
    dec.funct7b5 = in_ir[30];
    dec.illegal  = !is_legal(op);
  end

  // Output register next state: flush, load, bubble or hold
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      out_d       = '0;
      out_valid_d = 1'b0;
    end else if (in_valid && in_ready) begin
      out_d       = dec;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_pc       = out_q.pc;
  assign out_rs1      = out_q.rs1;
  assign out_rs2      = out_q.rs2;
  assign out_imm      = out_q.imm;
  assign out_rd_addr  = out_q.rd_addr;
  assign out_rd_en    = out_q.rd_en;
  assign out_opcode   = out_q.opcode;
  assign out_funct3   = out_q.funct3;
  assign out_funct7b5 = out_q.funct7b5;
  assign out_illegal  = out_q.illegal;

endmodule

// File: tb/tb_decode.sv
// Directed bench for the decode stage: bypass, interlock,
// back-pressure, flush, immediates, illegal opcode, reset.
module tb_decode;
  import riscv::*;

  logic       clk;
  logic       resetn;
  addr_t      rs1_addr, rs2_addr;
  word_t      rs1_data, rs2_data;
  logic       ex_rd_en, ex_is_load;
  addr_t      ex_rd_addr;
  word_t      ex_rd_data;
  logic       mem_rd_en;
  addr_t      mem_rd_addr;
  word_t      mem_rd_data;
  logic       flush;
  word_t      out_rs1, out_rs2, out_imm;
  addr_t      out_rd_addr;
  logic       out_rd_en;
  logic [6:0] out_opcode;
  logic [2:0] out_funct3;
  logic       out_funct7b5, out_illegal;

  int passed = 0;
  int total  = 0;

  decode_if bus ();

  decode dut (
    .clk          (clk),
    .resetn       (resetn),
    .in_valid     (bus.in_valid),
    .in_ready     (bus.in_ready),
    .in_pc        (bus.in_pc),
    .in_ir        (bus.in_ir),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .ex_rd_en     (ex_rd_en),
    .ex_rd_addr   (ex_rd_addr),
    .ex_rd_data   (ex_rd_data),
    .ex_is_load   (ex_is_load),
    .mem_rd_en    (mem_rd_en),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_data  (mem_rd_data),
    .flush        (flush),
    .out_valid    (bus.out_valid),
    .out_ready    (bus.out_ready),
    .out_pc       (bus.out_pc),
    .out_rs1      (out_rs1),
    .out_rs2      (out_rs2),
    .out_imm      (out_imm),
    .out_rd_addr  (out_rd_addr),
    .out_rd_en    (out_rd_en),
    .out_opcode   (out_opcode),
    .out_funct3   (out_funct3),
    .out_funct7b5 (out_funct7b5),
    .out_illegal  (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn          = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_pc       = '0;
    bus.in_ir       = '0;
    bus.out_ready   = 1'b1;
    rs1_data        = '0;
    rs2_data        = '0;
    ex_rd_en        = 1'b0;
    ex_rd_addr      = '0;
    ex_rd_data      = '0;
    ex_is_load      = 1'b0;
    mem_rd_en       = 1'b0;
    mem_rd_addr     = '0;
    mem_rd_data     = '0;
    flush           = 1'b0;

    // reset state
    step();
    step();
    resetn = 1'b1;
    #1;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_pc", bus.out_pc, 32'h0);
    chk("rst_imm", out_imm, 32'h0);

    // addi x1,x0,5 with garbage register file data
    bus.in_valid = 1'b1;
    bus.in_pc    = 32'h100;
    bus.in_ir    = 32'h00500093;
    rs1_data     = 32'hDEADBEEF;
    rs2_data     = 32'hCAFEF00D;
    #1;
    chk("addi_rs1a", 32'(rs1_addr), 32'd0);
    chk("addi_rs2a", 32'(rs2_addr), 32'd5);
    step();
    chk("addi_valid", 32'(bus.out_valid), 32'd1);
    chk("addi_imm", out_imm, 32'd5);
    chk("addi_rd", 32'(out_rd_addr), 32'd1);
    chk("addi_rden", 32'(out_rd_en), 32'd1);
    chk("addi_rs1", out_rs1, 32'd0);
    chk("addi_pc", bus.out_pc, 32'h100);
    chk("addi_op", 32'(out_opcode), 32'h13);

    // add x3,x1,x2: ex beats mem on x1, x2 from RF
    bus.in_pc   = 32'h104;
    bus.in_ir   = 32'h002081B3;
    ex_rd_en    = 1'b1;
    ex_rd_addr  = 5'd1;
    ex_rd_data  = 32'h11;
    mem_rd_en   = 1'b1;
    mem_rd_addr = 5'd1;
    mem_rd_data = 32'h22;
    rs1_data    = 32'h99;
    rs2_data    = 32'h55;
    #1;
    chk("add_ready", 32'(bus.in_ready), 32'd1);
    step();
    chk("add_rs1", out_rs1, 32'h11);
    chk("add_rs2", out_rs2, 32'h55);
    chk("add_rd", 32'(out_rd_addr), 32'd3);
    chk("add_rden", 32'(out_rd_en), 32'd1);

    // load-use on x1: interlock, bubble
    bus.in_pc  = 32'h108;
    ex_is_load = 1'b1;
    #1;
    chk("lu_ready", 32'(bus.in_ready), 32'd0);
    step();
    chk("lu_bubble", 32'(bus.out_valid), 32'd0);

    // load now in mem: release with mem-forwarded x1
    ex_is_load  = 1'b0;
    ex_rd_en    = 1'b0;
    mem_rd_data = 32'h77;
    #1;
    chk("lu_release", 32'(bus.in_ready), 32'd1);
    step();
    chk("lu_valid", 32'(bus.out_valid), 32'd1);
    chk("lu_rs1", out_rs1, 32'h77);
    chk("lu_pc", bus.out_pc, 32'h108);

    // back-pressure for 3 cycles
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    mem_rd_data   = 32'hABCD;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready", 32'(bus.in_ready), 32'd0);
      step();
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_pc", bus.out_pc, 32'h108);
      chk("bp_rs1", out_rs1, 32'h77);
    end
    bus.out_ready = 1'b1;
    step();
    chk("bp_one_xfer", 32'(bus.out_valid), 32'd0);
    mem_rd_en = 1'b0;

    // beq with B immediate -4, then held
    bus.in_valid  = 1'b1;
    bus.in_pc     = 32'h10C;
    bus.in_ir     = 32'hFE000EE3;
    step();
    chk("beq_valid", 32'(bus.out_valid), 32'd1);
    chk("beq_imm", out_imm, 32'hFFFFFFFC);
    chk("beq_rden", 32'(out_rd_en), 32'd0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    step();
    chk("beq_hold", 32'(bus.out_valid), 32'd1);

    // flush during hold, offered instruction dropped
    flush        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_pc    = 32'h110;
    bus.in_ir    = 32'h00500093;
    step();
    chk("flush_valid", 32'(bus.out_valid), 32'd0);
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;

    // illegal opcode 0x7F, rd=x1
    bus.in_valid = 1'b1;
    bus.in_pc    = 32'h114;
    bus.in_ir    = 32'h000000FF;
    step();
    chk("ill_valid", 32'(bus.out_valid), 32'd1);
    chk("ill_flag", 32'(out_illegal), 32'd1);
    chk("ill_rden", 32'(out_rd_en), 32'd0);
    chk("ill_imm", out_imm, 32'h0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    // asynchronous reset between edges
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_pc", bus.out_pc, 32'h0);
    #1;
    resetn = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk("arst_ready", 32'(bus.in_ready), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
